// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised redirects (trap > EX > ID), sequential stepping,
// stall/ready hold with capture of redirects that arrive while the PC is frozen.
module pc_gen #(
   parameter int unsigned      XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter bit               C_EXT        = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_addr,
   input  logic            ex_redir_valid,
   input  logic [XLEN-1:0] ex_redir_addr,
   input  logic            id_redir_valid,
   input  logic [XLEN-1:0] id_redir_addr,
   input  logic            inst_len2,
   input  logic            if_req_ready,
   output logic            if_req_valid,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_seq,
   output logic            redir_pending
);

   typedef enum logic [1:0] {StBoot, StRun, StHold} state_t;

   // Low address bits that a target may not carry.
   localparam logic [XLEN-1:0] AlignMask = C_EXT ? ~XLEN'(1) : ~XLEN'(3);

   localparam logic [1:0] PrioNone = 2'd0;
   localparam logic [1:0] PrioId   = 2'd1;
   localparam logic [1:0] PrioEx   = 2'd2;
   localparam logic [1:0] PrioTrap = 2'd3;

   state_t          state;
   logic [XLEN-1:0] pend_addr;
   logic [1:0]      pend_prio;
   logic [1:0]      new_prio;
   logic [XLEN-1:0] new_addr;
   logic [XLEN-1:0] step;
   logic            adv;
   logic            take_new;

   always_comb begin
      new_prio = PrioNone;
      new_addr = '0;
      if (trap_valid) begin
         new_prio = PrioTrap;
         new_addr = trap_addr & AlignMask;
      end else if (ex_redir_valid) begin
         new_prio = PrioEx;
         new_addr = ex_redir_addr & AlignMask;
      end else if (id_redir_valid) begin
         new_prio = PrioId;
         new_addr = id_redir_addr & AlignMask;
      end
   end

   assign step     = (C_EXT && inst_len2) ? XLEN'(2) : XLEN'(4);
   assign pc_seq   = pc_out + step;
   assign adv      = if_req_valid & if_req_ready & ~stall;
   // pend_prio is PrioNone whenever nothing is pending, so any redirect beats it; ties go to
   // the newer request.
   assign take_new = (new_prio != PrioNone) && (new_prio >= pend_prio);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= StBoot;
         pc_out        <= RESET_VECTOR;
         if_req_valid  <= 1'b0;
         redir_pending <= 1'b0;
         pend_addr     <= '0;
         pend_prio     <= PrioNone;
      end else begin
         unique case (state)
            StBoot: begin
               state        <= StRun;
               if_req_valid <= 1'b1;
            end
            StRun, StHold: begin
               if (adv) begin
                  if (take_new) begin
                     pc_out <= new_addr;
                  end else if (redir_pending) begin
                     pc_out <= pend_addr;
                  end else begin
                     pc_out <= pc_seq;
                  end
                  redir_pending <= 1'b0;
                  pend_prio     <= PrioNone;
                  state         <= StRun;
               end else begin
                  state <= StHold;
                  if (take_new) begin
                     pend_addr     <= new_addr;
                     pend_prio     <= new_prio;
                     redir_pending <= 1'b1;
                  end
               end
            end
            default: begin
               state        <= StBoot;
               if_req_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected fetch PCs are queued as stimulus is driven and
// compared after each clock edge; a C_EXT=1 instance shares the inputs.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        trap_valid = 1'b0;
   logic        ex_redir_valid = 1'b0;
   logic        id_redir_valid = 1'b0;
   logic        inst_len2 = 1'b0;
   logic        if_req_ready = 1'b1;
   logic [31:0] trap_addr = '0;
   logic [31:0] ex_redir_addr = '0;
   logic [31:0] id_redir_addr = '0;

   logic        if_req_valid, redir_pending;
   logic [31:0] pc_out, pc_seq;
   logic        c_valid, c_pending;
   logic [31:0] c_pc, c_seq;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] expc_q[$];
   logic [31:0] exp;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .trap_valid(trap_valid), .trap_addr(trap_addr),
      .ex_redir_valid(ex_redir_valid), .ex_redir_addr(ex_redir_addr),
      .id_redir_valid(id_redir_valid), .id_redir_addr(id_redir_addr),
      .inst_len2(inst_len2), .if_req_ready(if_req_ready),
      .if_req_valid(if_req_valid), .pc_out(pc_out), .pc_seq(pc_seq),
      .redir_pending(redir_pending)
   );

   pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1)) dut_c (
      .clk(clk), .rst(rst), .stall(stall),
      .trap_valid(trap_valid), .trap_addr(trap_addr),
      .ex_redir_valid(ex_redir_valid), .ex_redir_addr(ex_redir_addr),
      .id_redir_valid(id_redir_valid), .id_redir_addr(id_redir_addr),
      .inst_len2(inst_len2), .if_req_ready(if_req_ready),
      .if_req_valid(c_valid), .pc_out(c_pc), .pc_seq(c_seq),
      .redir_pending(c_pending)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redir();
      trap_valid     = 1'b0;
      ex_redir_valid = 1'b0;
      id_redir_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_req_valid); end
      n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc_out); end
      n_checks++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", redir_pending); end
      tick();
      tick();
      rst = 1'b1;
      n_checks++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b exp 0", if_req_valid); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'(i * 4));
         tick();
         exp = exp_q.pop_front();
         n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL seq_pc%0d got %h exp %h", i, pc_out, exp); end
         n_checks++; if (if_req_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d got %b exp 1", i, if_req_valid); end
      end
   endtask

   task automatic test_ex_priority();
      ex_redir_valid = 1'b1; ex_redir_addr = 32'h100;
      id_redir_valid = 1'b1; id_redir_addr = 32'h200;
      exp_q.push_back(32'h100);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL ex_over_id got %h exp %h", pc_out, exp); end
      clear_redir();
      exp_q.push_back(32'h104);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL after_ex_seq got %h exp %h", pc_out, exp); end
   endtask

   task automatic test_hold_capture();
      id_redir_valid = 1'b1; id_redir_addr = 32'h10;
      exp_q.push_back(32'h10);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL id_redir got %h exp %h", pc_out, exp); end
      stall = 1'b1;
      id_redir_addr = 32'h40;
      tick();
      n_checks++; if (redir_pending !== 1'b1) begin n_fail++; $display("FAIL hold_pend1 got %b exp 1", redir_pending); end
      n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL hold_pc1 got %h exp 10", pc_out); end
      clear_redir();
      trap_valid = 1'b1; trap_addr = 32'h80;
      tick();
      n_checks++; if (redir_pending !== 1'b1) begin n_fail++; $display("FAIL hold_pend2 got %b exp 1", redir_pending); end
      n_checks++; if (pc_out !== 32'h10) begin n_fail++; $display("FAIL hold_pc2 got %h exp 10", pc_out); end
      n_checks++; if (if_req_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b exp 1", if_req_valid); end
      clear_redir();
      stall = 1'b0;
      exp_q.push_back(32'h80);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL hold_exit_pc got %h exp %h", pc_out, exp); end
      n_checks++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL hold_exit_pend got %b exp 0", redir_pending); end
   endtask

   task automatic test_drop_lower();
      stall = 1'b1;
      trap_valid = 1'b1; trap_addr = 32'h80;
      tick();
      clear_redir();
      ex_redir_valid = 1'b1; ex_redir_addr = 32'h40;
      tick();
      n_checks++; if (redir_pending !== 1'b1) begin n_fail++; $display("FAIL drop_pend got %b exp 1", redir_pending); end
      clear_redir();
      stall = 1'b0;
      exp_q.push_back(32'h80);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL drop_lower_pc got %h exp %h", pc_out, exp); end
      // Not-ready hold: a higher same-cycle redirect at exit beats the pending one.
      if_req_ready = 1'b0;
      id_redir_valid = 1'b1; id_redir_addr = 32'h500;
      tick();
      n_checks++; if (pc_out !== 32'h80) begin n_fail++; $display("FAIL notready_pc got %h exp 80", pc_out); end
      n_checks++; if (redir_pending !== 1'b1) begin n_fail++; $display("FAIL notready_pend got %b exp 1", redir_pending); end
      clear_redir();
      if_req_ready = 1'b1;
      ex_redir_valid = 1'b1; ex_redir_addr = 32'h600;
      exp_q.push_back(32'h600);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL exit_new_wins got %h exp %h", pc_out, exp); end
      clear_redir();
      // Pending trap outranks a same-cycle ID jump at exit.
      if_req_ready = 1'b0;
      trap_valid = 1'b1; trap_addr = 32'h700;
      tick();
      clear_redir();
      if_req_ready = 1'b1;
      id_redir_valid = 1'b1; id_redir_addr = 32'h800;
      exp_q.push_back(32'h700);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL exit_pend_wins got %h exp %h", pc_out, exp); end
      clear_redir();
      exp_q.push_back(32'h704);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL exit_then_seq got %h exp %h", pc_out, exp); end
   endtask

   task automatic test_compressed();
      ex_redir_valid = 1'b1; ex_redir_addr = 32'h6;
      exp_q.push_back(32'h4);
      expc_q.push_back(32'h6);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL align4_pc got %h exp %h", pc_out, exp); end
      exp = expc_q.pop_front();
      n_checks++; if (c_pc !== exp) begin n_fail++; $display("FAIL align2_pc got %h exp %h", c_pc, exp); end
      clear_redir();
      inst_len2 = 1'b1;
      #1;
      n_checks++; if (c_seq !== 32'h8) begin n_fail++; $display("FAIL c_seq2 got %h exp 8", c_seq); end
      n_checks++; if (pc_seq !== 32'h8) begin n_fail++; $display("FAIL nc_seq4 got %h exp 8", pc_seq); end
      exp_q.push_back(32'h8);
      expc_q.push_back(32'h8);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL nc_step got %h exp %h", pc_out, exp); end
      exp = expc_q.pop_front();
      n_checks++; if (c_pc !== exp) begin n_fail++; $display("FAIL c_step2 got %h exp %h", c_pc, exp); end
      exp_q.push_back(32'hC);
      expc_q.push_back(32'hA);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL nc_step_b got %h exp %h", pc_out, exp); end
      exp = expc_q.pop_front();
      n_checks++; if (c_pc !== exp) begin n_fail++; $display("FAIL c_step2_b got %h exp %h", c_pc, exp); end
      inst_len2 = 1'b0;
      ex_redir_valid = 1'b1; ex_redir_addr = 32'h102;
      exp_q.push_back(32'h100);
      expc_q.push_back(32'h102);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL align4_102 got %h exp %h", pc_out, exp); end
      exp = expc_q.pop_front();
      n_checks++; if (c_pc !== exp) begin n_fail++; $display("FAIL align2_102 got %h exp %h", c_pc, exp); end
      clear_redir();
   endtask

   task automatic test_wrap_reset();
      ex_redir_valid = 1'b1; ex_redir_addr = 32'hFFFF_FFFC;
      exp_q.push_back(32'hFFFF_FFFC);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL wrap_setup got %h exp %h", pc_out, exp); end
      clear_redir();
      n_checks++; if (pc_seq !== 32'h0) begin n_fail++; $display("FAIL wrap_seq got %h exp 0", pc_seq); end
      exp_q.push_back(32'h0);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL wrap_pc got %h exp %h", pc_out, exp); end
      exp_q.push_back(32'h4);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL wrap_next got %h exp %h", pc_out, exp); end
      stall = 1'b1;
      trap_valid = 1'b1; trap_addr = 32'h80;
      tick();
      clear_redir();
      n_checks++; if (redir_pending !== 1'b1) begin n_fail++; $display("FAIL pre_rst_pend got %b exp 1", redir_pending); end
      #2 rst = 1'b0;
      #1;
      n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL async_rst_pc got %h exp 0", pc_out); end
      n_checks++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL async_rst_pend got %b exp 0", redir_pending); end
      n_checks++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b exp 0", if_req_valid); end
      stall = 1'b0;
      tick();
      rst = 1'b1;
      n_checks++; if (if_req_valid !== 1'b0) begin n_fail++; $display("FAIL reboot_valid got %b exp 0", if_req_valid); end
      exp_q.push_back(32'h0);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL reboot_pc got %h exp %h", pc_out, exp); end
      n_checks++; if (if_req_valid !== 1'b1) begin n_fail++; $display("FAIL reboot_run got %b exp 1", if_req_valid); end
      n_checks++; if (redir_pending !== 1'b0) begin n_fail++; $display("FAIL reboot_pend got %b exp 0", redir_pending); end
      exp_q.push_back(32'h4);
      tick();
      exp = exp_q.pop_front();
      n_checks++; if (pc_out !== exp) begin n_fail++; $display("FAIL reboot_seq got %h exp %h", pc_out, exp); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_ex_priority();
      test_hold_capture();
      test_drop_lower();
      test_compressed();
      test_wrap_reset();
      n_checks++;
      if (exp_q.size() != 0 || expc_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d/%0d exp 0/0", exp_q.size(), expc_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
